// File: rtl/idma_txrx_tx_framer.sv
// idma_txrx_tx_framer
//   Turns TXRX write bursts into link frames. Each burst becomes one header
//   word carrying the burst address, followed by its data beats. Beats with
//   an all-zero strobe are dropped unless they close the burst. Words pass
//   through a small registered FIFO. When the FIFO has drained, a completion
//   response reports how many data words were forwarded.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   req_valid_i/ready  write beat handshake; req_addr_i is sampled on the first beat
//   req_data_i/strb_i  beat payload and byte strobe; req_last_i marks the final beat
//   tx_valid_o/ready_i link word handshake; tx_hdr_o marks the header word,
//                      tx_last_o marks the final word of the frame
//   tx_data_o/strb_o   link word payload and strobe
//   rsp_valid_o/ready  burst completion handshake; rsp_beats_o is the data word count
//   busy_o             FSM active or FIFO holding words
module idma_txrx_tx_framer #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_data_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    input  logic                   req_last_i,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [DataWidth-1:0]   tx_data_o,
    output logic [DataWidth/8-1:0] tx_strb_o,
    output logic                   tx_hdr_o,
    output logic                   tx_last_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [15:0]            rsp_beats_o,
    output logic                   busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(FifoDepth);
    localparam int unsigned CntWidth  = $clog2(FifoDepth + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdr   = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    if (AddrWidth > DataWidth) begin : gen_addr_width_check
        $error("AddrWidth must not exceed DataWidth");
    end
    if (FifoDepth < 2) begin : gen_depth_check
        $error("FifoDepth must be at least 2");
    end
    if ((DataWidth % 8) != 0) begin : gen_data_width_check
        $error("DataWidth must be a multiple of 8");
    end

    logic [2:0]           state_q, state_d;
    logic [15:0]          beat_cnt_q, beat_cnt_d;
    logic [15:0]          rsp_beats_q, rsp_beats_d;

    // FIFO storage and pointers
    logic [DataWidth-1:0] mem_data [FifoDepth];
    logic [StrbWidth-1:0] mem_strb [FifoDepth];
    logic                 mem_hdr  [FifoDepth];
    logic                 mem_last [FifoDepth];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;
    logic [DataWidth-1:0] push_data;
    logic [StrbWidth-1:0] push_strb;
    logic                 push_hdr, push_last;
    logic [DataWidth-1:0] hdr_data;
    logic                 cnt_clr, cnt_inc;

    assign fifo_full  = (count_q == CntWidth'(FifoDepth));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && tx_ready_i;

    // Address is zero-extended into the header word
    always_comb begin
        hdr_data = '0;
        hdr_data[AddrWidth-1:0] = req_addr_i;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        push        = 1'b0;
        push_data   = '0;
        push_strb   = '0;
        push_hdr    = 1'b0;
        push_last   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        rsp_beats_d = rsp_beats_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) state_d = StHdr;
            end
            StHdr: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = hdr_data;
                    push_strb = '1;
                    push_hdr  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = StData;
                end
            end
            StData: begin
                // Gated on full only: a pop in the same cycle does not make room
                req_ready_o = !fifo_full;
                if (req_valid_i && !fifo_full) begin
                    push_data = req_data_i;
                    push_strb = req_strb_i;
                    if (req_last_i) begin
                        // The closing beat is always forwarded so the frame gets its last word
                        push      = 1'b1;
                        push_last = 1'b1;
                        cnt_inc   = 1'b1;
                        state_d   = StDrain;
                    end else if (|req_strb_i) begin
                        push    = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    rsp_beats_d = beat_cnt_q;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (cnt_clr) begin
            beat_cnt_d = '0;
        end else if (cnt_inc && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            rsp_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_beats_q <= rsp_beats_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr_q] <= push_data;
            mem_strb[wr_ptr_q] <= push_strb;
            mem_hdr[wr_ptr_q]  <= push_hdr;
            mem_last[wr_ptr_q] <= push_last;
        end
    end

    assign tx_valid_o  = !fifo_empty;
    assign tx_data_o   = fifo_empty ? '0 : mem_data[rd_ptr_q];
    assign tx_strb_o   = fifo_empty ? '0 : mem_strb[rd_ptr_q];
    assign tx_hdr_o    = !fifo_empty && mem_hdr[rd_ptr_q];
    assign tx_last_o   = !fifo_empty && mem_last[rd_ptr_q];
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_beats_o = rsp_beats_q;
    assign busy_o      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_idma_txrx_tx_framer.sv
module tb_idma_txrx_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_last;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_strb;
    logic        tx_valid, tx_ready, tx_hdr, tx_last;
    logic [31:0] tx_data;
    logic [3:0]  tx_strb;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_beats;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int beats_sent;
    bit abort;

    logic [3:0]  pat_strb [16];
    int          pat_n;
    logic [37:0] got_q [$];
    logic [37:0] exp_q [$];

    idma_txrx_tx_framer #(
        .DataWidth(32),
        .AddrWidth(32),
        .FifoDepth(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_strb_i (req_strb),
        .req_last_i (req_last),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_strb_o  (tx_strb),
        .tx_hdr_o   (tx_hdr),
        .tx_last_o  (tx_last),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_beats_o(rsp_beats),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Record every link word accepted at the next rising edge
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back({tx_hdr, tx_last, tx_strb, tx_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] addr, input int i);
        return {addr[15:0], 8'hD0, 8'(i)};
    endfunction

    // Expected frame: header, then every beat with nonzero strobe, plus the last beat
    task automatic build_exp(input logic [31:0] addr);
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 4'hF, addr});
        for (int i = 0; i < pat_n; i++) begin
            if ((i == pat_n - 1) || (pat_strb[i] != 4'h0))
                exp_q.push_back({1'b0, 1'(i == pat_n - 1), pat_strb[i], beat_data(addr, i)});
        end
    endtask

    // Called just after a rising edge
    task automatic drive_burst(input logic [31:0] addr);
        int guard;
        beats_sent = 0;
        req_valid  = 1'b1;
        req_addr   = addr;
        for (int i = 0; i < pat_n; i++) begin
            req_data = beat_data(addr, i);
            req_strb = pat_strb[i];
            req_last = (i == pat_n - 1);
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!req_ready && guard < 400 && !abort);
            if (abort) break;
            if (!req_ready) begin
                check("req_ready_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            beats_sent++;
        end
        req_valid = 1'b0;
        req_last  = 1'b0;
        req_strb  = '0;
    endtask

    // Wait for the response, check count and frame contents
    task automatic wait_rsp(input logic [31:0] addr, input int exp_beats, input int exp_words);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid && guard < 400);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_beats", 64'(rsp_beats), 64'(exp_beats));
        build_exp(addr);
        check("n_words", 64'(got_q.size()), 64'(exp_words));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
    endtask

    task automatic ack_rsp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; abort = 1'b0;
        req_valid = 0; req_addr = '0; req_data = '0; req_strb = '0; req_last = 0;
        tx_ready = 1'b1; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_tx_strb", 64'(tx_strb), 64'd0);
        check("rst_tx_hdr_last", 64'({tx_hdr, tx_last}), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_beats", 64'(rsp_beats), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain burst: hdr + 3 data words
        pat_n = 3; pat_strb[0] = 4'hF; pat_strb[1] = 4'hF; pat_strb[2] = 4'hF;
        drive_burst(32'h0000_1000);
        wait_rsp(32'h0000_1000, 3, 4);
        ack_rsp();

        // Zero-strobe beats dropped
        pat_n = 4; pat_strb[0] = 4'hF; pat_strb[1] = 4'h0; pat_strb[2] = 4'h0; pat_strb[3] = 4'h3;
        drive_burst(32'h0000_2000);
        wait_rsp(32'h0000_2000, 2, 3);
        ack_rsp();

        // Last beat with zero strobe still forwarded
        pat_n = 2; pat_strb[0] = 4'hF; pat_strb[1] = 4'h0;
        drive_burst(32'h0000_2400);
        wait_rsp(32'h0000_2400, 2, 3);
        ack_rsp();

        // Link backpressure: FIFO fills with header + 3 beats
        pat_n = 8;
        for (int i = 0; i < 8; i++) pat_strb[i] = 4'hF;
        tx_ready = 1'b0;
        fork
            drive_burst(32'h0000_3000);
        join_none
        repeat (20) @(negedge clk);
        check("bp_beats_queued", 64'(beats_sent), 64'd3);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_head_hdr", 64'({tx_valid, tx_hdr}), 64'b11);
        check("bp_head_data", 64'(tx_data), 64'h0000_3000);
        check("bp_got_none", 64'(got_q.size()), 64'd0);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait fork;
        wait_rsp(32'h0000_3000, 8, 9);
        ack_rsp();

        // Response stall with a second burst waiting
        pat_n = 2; pat_strb[0] = 4'hF; pat_strb[1] = 4'hF;
        rsp_ready = 1'b0;
        drive_burst(32'h0000_6000);
        fork
            drive_burst(32'h0000_7000);
        join_none
        wait_rsp(32'h0000_6000, 2, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rsp_beats", 64'({rsp_valid, rsp_beats}), {47'd0, 1'b1, 16'd2});
            check("stall_no_hdr", 64'(tx_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);     // response handshake edge
        @(negedge clk);
        check("post_hs_idle", 64'({rsp_valid, tx_valid}), 64'd0);
        @(negedge clk);
        check("post_hs_hdr_state", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check("post_hs_hdr_out", 64'({tx_valid, tx_hdr, tx_data}), {30'd0, 2'b11, 32'h0000_7000});
        wait fork;
        wait_rsp(32'h0000_7000, 2, 3);
        ack_rsp();

        // Reset in the middle of a 5-beat burst
        pat_n = 5;
        for (int i = 0; i < 5; i++) pat_strb[i] = 4'hF;
        fork
            drive_burst(32'h0000_4000);
        join_none
        begin
            int guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (beats_sent < 2 && guard < 200);
        end
        check("mid_beats_sent", 64'(beats_sent), 64'd2);
        #2;
        rst = 1'b1;
        abort = 1'b1;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd0);
        check("arst_tx", 64'({tx_valid, tx_hdr, tx_last, tx_strb}), 64'd0);
        check("arst_tx_data", 64'(tx_data), 64'd0);
        check("arst_rsp", 64'({rsp_valid, rsp_beats}), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        wait fork;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        abort = 1'b0;
        got_q.delete();
        @(posedge clk);
        #1;
        pat_n = 3;
        drive_burst(32'h0000_5000);
        wait_rsp(32'h0000_5000, 3, 4);
        ack_rsp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
